// File: rtl/alu_if.sv
// ALU operand/result bundle.
// Master drives operands and opcode; slave returns result and flags.
interface alu_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALU_select;
    logic [31:0] out;
    logic        zero_flag;
    logic        carry_flag;
    logic        overflow_flag;
    logic        sign_flag;

    modport master (
        output A, B, ALU_select,
        input  out, zero_flag, carry_flag, overflow_flag, sign_flag
    );

    modport slave (
        input  A, B, ALU_select,
        output out, zero_flag, carry_flag, overflow_flag, sign_flag
    );
endinterface

// File: rtl/alu.sv
// RV32I ALU with registered result and adder-derived condition flags.
// One-cycle latency, full throughput, synchronous active-high reset.
module alu (
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);
    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_PASS = 4'b0011,
        OP_OR   = 4'b0100,
        OP_AND  = 4'b0101,
        OP_XOR  = 4'b0111,
        OP_SLL  = 4'b1000,
        OP_SRL  = 4'b1001,
        OP_SRA  = 4'b1010,
        OP_SLT  = 4'b1101,
        OP_SLTU = 4'b1111
    } op_e;

    logic        is_add;
    logic [31:0] b_op;
    logic [32:0] sum;
    logic        zero_c;
    logic        carry_c;
    logic        ovf_c;
    logic        sign_c;
    logic [4:0]  shamt;
    logic [31:0] res_c;

    // Shared adder: add only for ADD, every other code subtracts so
    // the flags always reflect a compare of A against B.
    always_comb begin
        is_add  = (bus.ALU_select == OP_ADD);
        b_op    = is_add ? bus.B : ~bus.B;
        sum     = {1'b0, bus.A} + {1'b0, b_op} + {32'd0, ~is_add};
        zero_c  = (sum[31:0] == 32'd0);
        carry_c = sum[32];
        sign_c  = sum[31];
        ovf_c   = (bus.A[31] == b_op[31]) && (sum[31] != bus.A[31]);
    end

    // Result mux; undefined codes produce zero.
    always_comb begin
        shamt = bus.B[4:0];
        res_c = 32'd0;
        case (bus.ALU_select)
            OP_ADD:  res_c = sum[31:0];
            OP_SUB:  res_c = sum[31:0];
            OP_PASS: res_c = bus.B;
            OP_OR:   res_c = bus.A | bus.B;
            OP_AND:  res_c = bus.A & bus.B;
            OP_XOR:  res_c = bus.A ^ bus.B;
            OP_SLL:  res_c = bus.A << shamt;
            OP_SRL:  res_c = bus.A >> shamt;
            OP_SRA:  res_c = $unsigned($signed(bus.A) >>> shamt);
            OP_SLT:  res_c = {31'd0, sign_c ^ ovf_c};
            OP_SLTU: res_c = {31'd0, ~carry_c};
            default: res_c = 32'd0;
        endcase
    end

    // Output register; reset wins over any operation at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out           <= 32'd0;
            bus.zero_flag     <= 1'b0;
            bus.carry_flag    <= 1'b0;
            bus.overflow_flag <= 1'b0;
            bus.sign_flag     <= 1'b0;
        end else begin
            bus.out           <= res_c;
            bus.zero_flag     <= zero_c;
            bus.carry_flag    <= carry_c;
            bus.overflow_flag <= ovf_c;
            bus.sign_flag     <= sign_c;
        end
    end
endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: behavioural model plus directed literals.
// Inputs change on negedge; results are compared on the next negedge.
module tb_alu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    alu_if bus ();

    alu u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    localparam logic [35:0] M_OUT = {32'hFFFF_FFFF, 4'b0000};
    localparam logic [35:0] M_Z   = 36'h8;
    localparam logic [35:0] M_C   = 36'h4;
    localparam logic [35:0] M_V   = 36'h2;
    localparam logic [35:0] M_S   = 36'h1;
    localparam logic [35:0] M_ALL = {36{1'b1}};

    int passed = 0;
    int total  = 0;

    logic [35:0] lit_mask = '0;
    logic [35:0] lit_val  = '0;
    logic [35:0] exp_q    = '0;
    logic [35:0] lmask_q  = '0;
    logic [35:0] lval_q   = '0;
    logic        exp_valid = 1'b0;

    // Result packed as {out, zero, carry, overflow, sign}.
    function automatic logic [35:0] model(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [3:0]  sel
    );
        longint ua, ub, sa, sb, full, st;
        logic [31:0] r, res;
        logic carry, ovf;
        int sh;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sel == 4'd0) begin
            full  = ua + ub;
            carry = (full >= 64'h1_0000_0000);
            st    = sa + sb;
        end else begin
            full  = ua - ub;
            carry = (ua >= ub);
            st    = sa - sb;
        end
        r   = full[31:0];
        ovf = (st > 64'sd2147483647) || (st < -64'sd2147483648);
        sh  = int'(b % 32);
        case (sel)
            4'd0:    res = a + b;
            4'd1:    res = a - b;
            4'd3:    res = b;
            4'd4:    res = a | b;
            4'd5:    res = a & b;
            4'd7:    res = a ^ b;
            4'd8:    res = a << sh;
            4'd9:    res = a >> sh;
            4'd10:   res = $unsigned($signed(a) >>> sh);
            4'd13:   res = (sa < sb) ? 32'd1 : 32'd0;
            4'd15:   res = (ua < ub) ? 32'd1 : 32'd0;
            default: res = 32'd0;
        endcase
        return {res, (r == 32'd0), carry, ovf, r[31]};
    endfunction

    // Capture what the outputs must be after this edge.
    always @(posedge clk) begin
        exp_q     <= rst ? 36'd0 : model(bus.A, bus.B, bus.ALU_select);
        lmask_q   <= lit_mask;
        lval_q    <= lit_val;
        exp_valid <= 1'b1;
    end

    // Compare DUT against model every cycle, and against literals when set.
    always @(negedge clk) begin
        logic [35:0] act;
        act = {bus.out, bus.zero_flag, bus.carry_flag,
               bus.overflow_flag, bus.sign_flag};
        if (exp_valid) begin
            total++;
            if (act == exp_q) passed++;
            else $display("FAIL model: got %h expected %h", act, exp_q);
            if (lmask_q != 36'd0) begin
                total++;
                if ((act & lmask_q) == (lval_q & lmask_q)) passed++;
                else $display("FAIL literal: got %h expected %h mask %h",
                              act, lval_q, lmask_q);
            end
        end
    end

    task automatic drive(
        input logic        r,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [3:0]  sel,
        input logic [35:0] mask,
        input logic [35:0] val
    );
        @(negedge clk);
        rst            = r;
        bus.A          = a;
        bus.B          = b;
        bus.ALU_select = sel;
        lit_mask       = mask;
        lit_val        = val;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.A          = 32'hFFFF_FFFF;
        bus.B          = 32'hFFFF_FFFF;
        bus.ALU_select = 4'd0;

        drive(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd0, M_ALL, 36'd0);
        drive(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd0, M_ALL, 36'd0);
        drive(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd0,
              M_OUT | M_C, {32'hFFFF_FFFE, 4'b0100});
        drive(0, 15, 10, 4'd0, M_OUT | M_Z | M_C | M_V, {32'd25, 4'b0000});
        drive(0, 20, 5, 4'd1, M_OUT | M_C, {32'd15, 4'b0100});
        drive(0, 5, 5, 4'd1, M_OUT | M_Z | M_C, {32'd0, 4'b1100});
        drive(0, 32'h7FFF_FFFF, 1, 4'd0, M_OUT | M_V | M_S,
              {32'h8000_0000, 4'b0011});
        drive(0, 4'b1010, 4'b1100, 4'd4, M_OUT, {32'b1110, 4'b0});
        drive(0, 4'b1010, 4'b1100, 4'd5, M_OUT, {32'b1000, 4'b0});
        drive(0, 4'b1010, 4'b1100, 4'd7, M_OUT, {32'b0110, 4'b0});
        drive(0, 4'b1010, 4'b1100, 4'd3, M_OUT, {32'b1100, 4'b0});
        drive(0, 1, 2, 4'd8, M_OUT, {32'd4, 4'b0});
        drive(0, 8, 2, 4'd9, M_OUT, {32'd2, 4'b0});
        drive(0, 32'h8000_0000, 2, 4'd10, M_OUT, {32'hE000_0000, 4'b0});
        drive(0, 32'h8000_0000, 32'h22, 4'd9, M_OUT, {32'h2000_0000, 4'b0});
        drive(0, 5, 10, 4'd13, M_OUT, {32'd1, 4'b0});
        drive(0, 5, 5, 4'd13, M_OUT, {32'd0, 4'b0});
        drive(0, 32'hFFFF_FFFF, 1, 4'd13, M_OUT, {32'd1, 4'b0});
        drive(0, 5, 10, 4'd15, M_OUT, {32'd1, 4'b0});
        drive(0, 32'hFFFF_FFFF, 1, 4'd15, M_OUT, {32'd0, 4'b0});
        drive(0, 32'h8000_0000, 1, 4'd13, M_OUT | M_V, {32'd1, 4'b0010});
        drive(0, 3, 3, 4'd6, M_OUT | M_Z, {32'd0, 4'b1000});
        drive(1, 32'h1234, 32'h5678, 4'd0, M_ALL, 36'd0);

        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 49) == 0), pick(), pick(),
                  4'($urandom_range(0, 15)), 36'd0, 36'd0);
        end

        drive(0, 0, 0, 4'd0, 36'd0, 36'd0);
        @(negedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
